msix_intr_gen: RTL
==================

Name: msix_intr_gen

Overview:
Device-side MSI-X message generator, the initiator end of the host interrupt path. It holds a per-vector table of address, data and mask, and latches interrupt events into a pending bit array (PBA). It round-robin arbitrates pending unmasked vectors and issues one DW memory write per message toward the host, where the host model detects the write to the vector address as the interrupt.

Parameters:
NUM_VEC, 8, number of MSI-X vectors (2..64)
IDX_W, $clog2(NUM_VEC), vector index width
HOLDOFF, 16, minimum idle cycles between messages (used only with MSIX_HOLDOFF_EN)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
msix_en  in  1  MSI-X enable; 0 = no messages issued, events still latch to PBA
func_mask  in  1  function mask; 1 = all vectors masked
cfg_we  in  1  table write strobe
cfg_idx  in  IDX_W  table entry index
cfg_addr  in  64  message address; bits [1:0] forced 0 on write
cfg_data  in  32  message data
cfg_mask  in  1  per-vector mask
intr_req  in  NUM_VEC  one-cycle event pulse per vector
wr_valid  out  1  message write valid
wr_addr  out  64  message address
wr_data  out  32  message data
wr_ready  in  1  host side accepts write
pba  out  NUM_VEC  pending bit array
busy  out  1  1 while a message is in ARB/SEND

Behaviour:
- Reset (async assert, sync-released internally): table addr=0, data=0, mask=1 for every entry. pba=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0. FSM goes to IDLE and the arbiter pointer resets to 0. Reset mid-SEND drops wr_valid immediately; the message is lost.
- Table write: on clk with cfg_we=1, entry[cfg_idx] <= {cfg_addr & ~3, cfg_data, cfg_mask}. cfg_idx >= NUM_VEC is ignored.
- Pending: pba[i] set on clk when intr_req[i]=1. It is cleared only when message i completes the handshake. If intr_req[i] arrives in the same cycle as the clear of i, set wins and pba[i] stays 1.
- Eligible vector i: pba[i] & ~mask[i] & ~func_mask & msix_en.
- FSM:
  - IDLE -> ARB when any vector is eligible.
  - ARB (1 cycle): round-robin pick starting at pointer; latch the entry's addr/data into output registers; pointer <= pick+1 mod NUM_VEC. Go to SEND if the pick is still eligible, else IDLE.
  - SEND: wr_valid=1. wr_addr/wr_data stay stable until wr_valid&wr_ready. On handshake: clear pba[pick], wr_valid=0, go to IDLE (or HOLD with the feature).
- Once wr_valid=1 it must not drop until the handshake, even if msix_en, func_mask or the mask changes, or the table entry is rewritten. The latched values are sent.
- Latency: intr_req at cycle N, pba at N+1, ARB at N+1, wr_valid at N+2 with wr_ready=1. The handshake completes at N+2 and the next message can start ARB at N+3.
- Masked vector: the event stays in pba. A message is sent after unmask: mask cleared at cycle M, wr_valid at M+2.
- Multiple events on the same vector while pending coalesce into one message.
- busy = (state != IDLE).

Optional Feature:
MSIX_HOLDOFF_EN:
- Defined: after each handshake the FSM enters HOLD, and a counter loads HOLDOFF-1 and decrements to 0 before returning to IDLE. This guarantees at least HOLDOFF cycles from a handshake to the next wr_valid rise. Events still latch during HOLD, and busy=1 in HOLD.
- Undefined: there is no HOLD state and messages can be back-to-back every 2 cycles.

Decomposition:
- msix_pkg holds:
  - msix_state_e (IDLE, ARB, SEND, HOLD)
  - msix_vec_t struct {U64 addr; U32 data; bit mask}
  - MSIX_RST_MASK = 1
- msix_pkg uses the U64/U32 types from misc_pkg.
- Sub-module msix_rr_arb: a NUM_VEC-wide round-robin arbiter that takes req vector + pointer and returns grant index + valid. It is combinational, and the pointer register stays in msix_intr_gen.

Test Plan:
- Program vec 3 {addr 0x0000_1000_0000_0F04, data 0x0000_0033, mask 0}, msix_en=1, func_mask=0, pulse intr_req[3], wr_ready=1 -> wr_valid 2 cycles later with addr 0x1000_0000_0F04, data 0x33. pba[3] returns to 0 and busy is back to 0.
- Vec 5 masked, pulse intr_req[5] -> no wr_valid for 50 cycles and pba[5]=1. Clear mask -> exactly one write to vec 5's address, then pba=0.
- Pulse intr_req[0], [2] and [7] in the same cycle with wr_ready=1 -> writes in order 0, 2, 7. Then pulse [0] and [7] together -> order 0, 7 follows the round-robin pointer.
- wr_ready held 0 for 10 cycles, with cfg write to the in-flight vector and msix_en dropped mid-wait -> wr_addr/wr_data unchanged and wr_valid stays 1. With wr_ready=1 the original values complete the transfer.
- Pulse intr_req[1] on the exact cycle vec 1's handshake completes -> pba[1] remains 1 and a second write to vec 1 follows.
- Assert rst_n=0 during SEND -> wr_valid=0 and pba=0 at once, and all masks read back as 1. With MSIX_HOLDOFF_EN and HOLDOFF=16, back-to-back events -> 16 or more cycles between handshake and the next wr_valid.

Source files
------------

// File: rtl/misc_pkg.sv
// +-------------------------------------------------------------------+
// | misc_pkg : shared scalar type aliases                              |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
`default_nettype none

package misc_pkg;
   typedef logic [63:0] U64;
   typedef logic [31:0] U32;
endpackage

`default_nettype wire

// File: rtl/msix_pkg.sv
// +-------------------------------------------------------------------+
// | msix_pkg : MSI-X generator state encoding and vector table entry   |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
`default_nettype none

package msix_pkg;
   import misc_pkg::*;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARB  = 2'd1,
      SEND = 2'd2,
      HOLD = 2'd3
   } msix_state_e;

   typedef struct packed {
      U64   addr;
      U32   data;
      logic mask;
   } msix_vec_t;

   localparam logic MSIX_RST_MASK = 1'b1;
endpackage

`default_nettype wire

// File: rtl/msix_intr_gen_if.sv
// +-------------------------------------------------------------------+
// | msix_intr_gen_if : vector-table config port and message write bus  |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
`default_nettype none

interface msix_intr_gen_if
   import misc_pkg::*;
#(
   parameter int IDX_W = 3
);
   logic             cfg_we;
   logic [IDX_W-1:0] cfg_idx;
   U64               cfg_addr;
   U32               cfg_data;
   logic             cfg_mask;
   logic             wr_valid;
   U64               wr_addr;
   U32               wr_data;
   logic             wr_ready;

   modport master (
      input  cfg_we, cfg_idx, cfg_addr, cfg_data, cfg_mask, wr_ready,
      output wr_valid, wr_addr, wr_data
   );

   modport slave (
      output cfg_we, cfg_idx, cfg_addr, cfg_data, cfg_mask, wr_ready,
      input  wr_valid, wr_addr, wr_data
   );
endinterface

`default_nettype wire

// File: rtl/msix_rr_arb.sv
// +-------------------------------------------------------------------+
// | msix_rr_arb : combinational round-robin pick starting at ptr       |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
`default_nettype none

module msix_rr_arb #(
   parameter int NUM_VEC = 8,
   parameter int IDX_W   = $clog2(NUM_VEC)
) (
   input  logic [NUM_VEC-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   grant,
   output logic               valid
);
   int idx;

   // Scan from the farthest offset down so the request nearest ptr wins last.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = 0;
      for (int i = NUM_VEC - 1; i >= 0; i--) begin
         idx = int'(ptr) + i;
         if (idx >= NUM_VEC) idx = idx - NUM_VEC;
         if (req[idx[IDX_W-1:0]]) begin
            grant = idx[IDX_W-1:0];
            valid = 1'b1;
         end
      end
   end
endmodule

`default_nettype wire

// File: rtl/msix_intr_gen.sv
// +-------------------------------------------------------------------+
// | msix_intr_gen : MSI-X vector table, PBA and message write issuer   |
// | Optional macro MSIX_HOLDOFF_EN adds a HOLD gap after each message. |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
`default_nettype none

module msix_intr_gen
   import misc_pkg::*;
   import msix_pkg::*;
#(
   parameter int NUM_VEC = 8,
   parameter int IDX_W   = $clog2(NUM_VEC),
   parameter int HOLDOFF = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               msix_en,
   input  logic               func_mask,
   input  logic [NUM_VEC-1:0] intr_req,
   output logic [NUM_VEC-1:0] pba,
   output logic               busy,
   msix_intr_gen_if.master    bus
);
   if (NUM_VEC < 2 || NUM_VEC > 64 || HOLDOFF < 1) begin : g_bad_param
      $error("msix_intr_gen: illegal NUM_VEC or HOLDOFF");
   end

   logic [1:0]         rst_sync;
   logic               rst_i_n;
   msix_vec_t          table_q [NUM_VEC];
   logic [NUM_VEC-1:0] pba_q, pba_nxt, clr_vec, mask_vec, elig_vec, elig_nxt;
   msix_state_e        state, state_nxt;
   logic [IDX_W-1:0]   ptr, pick, arb_grant;
   logic               arb_valid, hs, glb_en;
   U64                 addr_q;
   U32                 data_q;

   // Reset asserts asynchronously but releases on a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_i_n = rst_sync[1];

   always_ff @(posedge clk or negedge rst_i_n) begin
      if (!rst_i_n) begin
         for (int i = 0; i < NUM_VEC; i++)
            table_q[i] <= '{addr: '0, data: '0, mask: MSIX_RST_MASK};
      end else if (bus.cfg_we && (32'(bus.cfg_idx) < NUM_VEC)) begin
         table_q[bus.cfg_idx] <= '{addr: bus.cfg_addr & ~64'h3,
                                   data: bus.cfg_data,
                                   mask: bus.cfg_mask};
      end
   end

   for (genvar g = 0; g < NUM_VEC; g++) begin : g_mask
      assign mask_vec[g] = table_q[g].mask;
   end

   assign glb_en = msix_en & ~func_mask;
   assign hs     = (state == SEND) & bus.wr_ready;

   always_comb begin
      clr_vec = '0;
      if (hs) clr_vec[pick] = 1'b1;
   end

   // A new event in the same cycle as its clear keeps the bit set.
   assign pba_nxt  = (pba_q & ~clr_vec) | intr_req;
   assign elig_vec = pba_q   & ~mask_vec & {NUM_VEC{glb_en}};
   assign elig_nxt = pba_nxt & ~mask_vec & {NUM_VEC{glb_en}};

   always_ff @(posedge clk or negedge rst_i_n) begin
      if (!rst_i_n) pba_q <= '0;
      else          pba_q <= pba_nxt;
   end

   msix_rr_arb #(
      .NUM_VEC (NUM_VEC),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req   (elig_vec),
      .ptr   (ptr),
      .grant (arb_grant),
      .valid (arb_valid)
   );

   always_ff @(posedge clk or negedge rst_i_n) begin
      if (!rst_i_n) begin
         addr_q <= '0;
         data_q <= '0;
         pick   <= '0;
         ptr    <= '0;
      end else if (state == ARB && arb_valid) begin
         addr_q <= table_q[arb_grant].addr;
         data_q <= table_q[arb_grant].data;
         pick   <= arb_grant;
         ptr    <= (arb_grant == IDX_W'(NUM_VEC - 1)) ? '0 : arb_grant + 1'b1;
      end
   end

`ifdef MSIX_HOLDOFF_EN
   localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   logic [HOLD_W-1:0] hold_cnt;

   always_ff @(posedge clk or negedge rst_i_n) begin
      if (!rst_i_n)                          hold_cnt <= '0;
      else if (hs)                           hold_cnt <= HOLD_W'(HOLDOFF - 1);
      else if (state == HOLD && hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
   end
`endif

   always_ff @(posedge clk or negedge rst_i_n) begin
      if (!rst_i_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (|elig_nxt) state_nxt = ARB;
         ARB:  state_nxt = arb_valid ? SEND : IDLE;
         SEND: begin
            if (hs) begin
`ifdef MSIX_HOLDOFF_EN
               state_nxt = HOLD;
`else
               state_nxt = (|elig_nxt) ? ARB : IDLE;
`endif
            end
         end
         HOLD: begin
`ifdef MSIX_HOLDOFF_EN
            if (hold_cnt == '0) state_nxt = IDLE;
`else
            state_nxt = IDLE;
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.wr_valid = (state == SEND);
      bus.wr_addr  = addr_q;
      bus.wr_data  = data_q;
      busy         = (state != IDLE);
      pba          = pba_q;
   end
endmodule

`default_nettype wire
